// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) priority encoder with valid/ready streams,
// fixed-priority or round-robin arbitration, and none/multi flags.
module prio_encoder_rr #(
    parameter int unsigned N       = 4,
    parameter int unsigned RR_MODE = 0,
    localparam int unsigned W      = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] in_req,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_none,
    output logic         out_multi
);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_idx_q,   out_idx_d;
    logic         out_none_q,  out_none_d;
    logic         out_multi_q, out_multi_d;
    logic [W-1:0] ptr_q,       ptr_d;

    logic         accept;
    logic         transfer;
    logic         hi_found;
    logic [W-1:0] hi_idx;
    logic [W-1:0] lo_idx;
    logic [W-1:0] grant_idx;
    logic         req_any;
    logic         req_multi;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign transfer = out_valid_q && out_ready;

    assign req_any   = |in_req;
    assign req_multi = |(in_req & (in_req - N'(1)));

    // Lowest set bit at or above ptr wins; otherwise lowest set bit overall.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_req[i]) begin
                lo_idx = W'(i);
                if (W'(i) >= ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = W'(i);
                end
            end
        end
        grant_idx = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_none_d  = out_none_q;
        out_multi_d = out_multi_q;
        ptr_d       = ptr_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_idx_d   = grant_idx;
            out_none_d  = !req_any;
            out_multi_d = req_multi;
            if ((RR_MODE != 0) && req_any) begin
                ptr_d = (grant_idx == W'(N - 1)) ? '0 : grant_idx + W'(1);
            end
        end else if (transfer) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_none_q  <= 1'b0;
            out_multi_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_none_q  <= out_none_d;
            out_multi_q <= out_multi_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_none  = out_none_q;
    assign out_multi = out_multi_q;

endmodule

// File: doc/prio_encoder_rr.md
Name: prio_encoder_rr

Overview:
- Parametrised, registered N-to-log2(N) priority encoder.
- Generalises the fixed 4-to-2 combinational encoder.
- Adds a valid/ready input and output stream, a one-cycle registered output, selectable fixed-priority or round-robin arbitration, and "no request" / "multiple request" flags.
- Sits between request sources (button/line samplers) and downstream consumers that need one index per transaction.

Parameters:
N, 4, number of request lines (N >= 2; need not be a power of 2)
W, $clog2(N), index width (derived; not to be overridden)
RR_MODE, 0, 0 = fixed priority (bit 0 highest), 1 = round-robin

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_req holds a request vector this cycle
in_req  input  N  request lines, bit i = requester i
in_ready  output  1  block can accept in_req this cycle
out_valid  output  1  out_* fields hold a result
out_ready  input  1  consumer takes the result this cycle
out_idx  output  W  index of the granted request line
out_none  output  1  accepted vector was all zeros
out_multi  output  1  accepted vector had two or more bits set

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_idx=0, out_none=0, out_multi=0.
  - Round-robin pointer ptr=0.
  - Asserting reset mid-transfer discards the held result.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; single output register, no skid buffer).
  - Accept occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Latency and throughput:
  - Latency is one cycle: a vector accepted at edge k is visible on out_* after edge k.
  - Sustained throughput is one vector per cycle while out_ready=1.
- Output hold: while out_valid && !out_ready, all out_* and ptr hold stable and in_ready=0.
- Drain without accept: out_valid clears on a transfer edge with no accept.
- Simultaneous transfer and accept: out_valid stays 1 and out_* load the new result.
- Fixed mode (RR_MODE=0): out_idx = lowest i with in_req[i]=1.
- Round-robin mode (RR_MODE=1):
  - out_idx = first set bit searching i = ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - On accept with a nonzero vector, ptr <= (out_idx+1) mod N; wrap N-1 -> 0 also for non-power-of-2 N.
  - In fixed mode ptr is constant 0.
- Zero vector: out_none=1, out_idx=0, out_multi=0, ptr unchanged.
- Flags are computed on the accepted vector:
  - out_multi=1 iff popcount(in_req) >= 2.
  - out_none=1 iff in_req==0.
- Invalid input: in_req is ignored when in_valid=0; ptr does not change.
- X-safety: none required beyond reset; all registers are reset.

Test Plan:
- Reset then N=4, fixed mode: in_req=4'b1010 accepted with out_ready=1 -> next cycle out_valid=1, out_idx=1, out_multi=1, out_none=0.
- Fixed mode, in_req=4'b0000 -> out_idx=0, out_none=1, out_multi=0. Then in_req=4'b1000 -> out_idx=3, out_none=0, out_multi=0.
- RR mode, N=4, in_req=4'b1111 held valid for 5 cycles with out_ready=1 -> out_idx sequence 0,1,2,3,0; out_multi=1 each cycle.
- RR mode, N=5: in_req=5'b10000 (ptr -> 0, wrap), then 5'b10001 -> out_idx 4 then 0. Then 5'b10001 again -> out_idx 4.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with new in_valid=1 -> in_ready=0; out_idx and ptr unchanged. Then out_ready=1 -> new vector accepted same cycle, out_valid stays 1.
- Assert rst_n=0 asynchronously between edges while out_valid=1, RR ptr=2 -> out_valid=0 immediately. After release, in_req=4'b1111 -> out_idx=0.
